// File: rtl/similarity_pkg.sv
// rtl/similarity_pkg.sv - shared types and widths for the similarity skip controller
package similarity_pkg;

  localparam int SKIP_W  = 3;
  localparam int STAT_W  = 16;
  localparam int COUNT_W = 8;
  localparam int WD_W    = 10;

  localparam int DEF_MAX_SKIP = 4;
  localparam int DEF_TIMEOUT  = 1023;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_DECIDE  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_REUSE   = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;

endpackage

// File: rtl/similarity_skip_ctrl_if.sv
// rtl/similarity_skip_ctrl_if.sv - frame, checker and compute handshakes of the skip controller
interface similarity_skip_ctrl_if;
  import similarity_pkg::*;

  logic               frame_valid;
  logic               frame_ready;
  logic [COUNT_W-1:0] row_count;
  logic               sm_idle;
  logic [COUNT_W-1:0] sm_count;
  logic               similarity_flag;
  logic               SM_done;
  logic               compute_start;
  logic               compute_done;
  logic               reuse_prev;
  logic               frame_done;
  logic [SKIP_W-1:0]  skip_cnt;
  logic [STAT_W-1:0]  stat_computed;
  logic [STAT_W-1:0]  stat_skipped;
  logic               timeout_err;

  modport master (
    output frame_valid, row_count, similarity_flag, SM_done, compute_done,
    input  frame_ready, sm_idle, sm_count, compute_start, reuse_prev, frame_done,
    input  skip_cnt, stat_computed, stat_skipped, timeout_err
  );

  modport slave (
    input  frame_valid, row_count, similarity_flag, SM_done, compute_done,
    output frame_ready, sm_idle, sm_count, compute_start, reuse_prev, frame_done,
    output skip_cnt, stat_computed, stat_skipped, timeout_err
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable up-counter that sticks at MAX
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/similarity_skip_ctrl.sv
// rtl/similarity_skip_ctrl.sv - decides per frame whether to recompute or reuse the previous result
module similarity_skip_ctrl
  import similarity_pkg::*;
#(
  parameter int MAX_SKIP = DEF_MAX_SKIP,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input logic                  clk,
  input logic                  rst,
  similarity_skip_ctrl_if.slave bus
);

  localparam logic [WD_W-1:0]   TIMEOUT_V  = WD_W'(TIMEOUT);
  localparam logic [SKIP_W-1:0] MAX_SKIP_V = SKIP_W'(MAX_SKIP);

  state_t             state, state_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               flag_q, flag_d;
  logic               first_frame, first_d;
  logic               sm_idle_q, sm_idle_d;
  logic [COUNT_W-1:0] sm_count_q, sm_count_d;
  logic               timeout_q, timeout_d;
  logic               start_q, start_d;
  logic               reuse_q, reuse_d;
  logic               done_q, done_d;
  logic               skip_inc, compute_exit;
  logic [SKIP_W-1:0]  skip_cnt;
  logic [STAT_W-1:0]  stat_computed, stat_skipped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wd_q        <= '0;
      flag_q      <= 1'b0;
      first_frame <= 1'b1;
      sm_idle_q   <= 1'b1;
      sm_count_q  <= '0;
      timeout_q   <= 1'b0;
      start_q     <= 1'b0;
      reuse_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_d;
      wd_q        <= wd_d;
      flag_q      <= flag_d;
      first_frame <= first_d;
      sm_idle_q   <= sm_idle_d;
      sm_count_q  <= sm_count_d;
      timeout_q   <= timeout_d;
      start_q     <= start_d;
      reuse_q     <= reuse_d;
      done_q      <= done_d;
    end
  end

  // SM_done is tested before the watchdog so a same-cycle arrival beats the timeout
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (bus.frame_valid) state_d = (bus.row_count == '0) ? ST_DECIDE : ST_CHECK;
      ST_CHECK:   if (bus.SM_done || (wd_q == TIMEOUT_V)) state_d = ST_DECIDE;
      ST_DECIDE:  state_d = (!flag_q && !first_frame && (skip_cnt < MAX_SKIP_V)) ? ST_REUSE : ST_COMPUTE;
      ST_COMPUTE: if (bus.compute_done) state_d = ST_FINISH;
      ST_REUSE:   state_d = ST_FINISH;
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wd_d         = '0;
    flag_d       = flag_q;
    first_d      = first_frame;
    sm_idle_d    = sm_idle_q;
    sm_count_d   = sm_count_q;
    timeout_d    = timeout_q;
    start_d      = (state == ST_DECIDE) && (state_d == ST_COMPUTE);
    reuse_d      = (state == ST_DECIDE) && (state_d == ST_REUSE);
    done_d       = (state != ST_FINISH) && (state_d == ST_FINISH);
    skip_inc     = reuse_d;
    compute_exit = (state == ST_COMPUTE) && bus.compute_done;
    case (state)
      ST_IDLE: begin
        sm_idle_d = 1'b1;
        if (bus.frame_valid) begin
          sm_count_d = bus.row_count;
          if (bus.row_count == '0) flag_d = 1'b1;
          else sm_idle_d = 1'b0;
        end
      end
      ST_CHECK: begin
        if (bus.SM_done) begin
          flag_d    = bus.similarity_flag;
          sm_idle_d = 1'b1;
        end else if (wd_q == TIMEOUT_V) begin
          flag_d    = 1'b1;
          timeout_d = 1'b1;
          sm_idle_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_COMPUTE: if (bus.compute_done) first_d = 1'b0;
      default: ;
    endcase
  end

  sat_counter #(.WIDTH(SKIP_W), .MAX(MAX_SKIP_V)) u_skip_cnt (
    .clk(clk), .rst(rst), .clr(compute_exit), .inc(skip_inc), .count(skip_cnt)
  );

  sat_counter #(.WIDTH(STAT_W)) u_stat_computed (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(compute_exit), .count(stat_computed)
  );

  sat_counter #(.WIDTH(STAT_W)) u_stat_skipped (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(skip_inc), .count(stat_skipped)
  );

  assign bus.frame_ready   = (state == ST_IDLE);
  assign bus.sm_idle       = sm_idle_q;
  assign bus.sm_count      = sm_count_q;
  assign bus.compute_start = start_q;
  assign bus.reuse_prev    = reuse_q;
  assign bus.frame_done    = done_q;
  assign bus.skip_cnt      = skip_cnt;
  assign bus.stat_computed = stat_computed;
  assign bus.stat_skipped  = stat_skipped;
  assign bus.timeout_err   = timeout_q;

endmodule

// File: tb/tb_similarity_skip_ctrl.sv
// tb/tb_similarity_skip_ctrl.sv - randomized self-checking bench for similarity_skip_ctrl
module tb_similarity_skip_ctrl;
  localparam int MAX_SKIP = 4;
  localparam int TIMEOUT  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  similarity_skip_ctrl_if bus();

  similarity_skip_ctrl #(.MAX_SKIP(MAX_SKIP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // reference: frame decision history
  bit m_first = 1'b1;
  int m_skip = 0, m_comp = 0, m_skipped = 0;

  function automatic bit model_frame(input bit eff_flag);
    bit reuse;
    reuse = !eff_flag && !m_first && (m_skip < MAX_SKIP);
    if (reuse) begin
      m_skip++;
      m_skipped++;
    end else begin
      m_skip  = 0;
      m_first = 1'b0;
      m_comp++;
    end
    return reuse;
  endfunction

  int o_start, o_reuse, o_done, o_idle_low;
  int o_sd_cyc, o_cd_cyc, o_fd_cyc, o_reuse_cyc;
  int o_skip_seen;

  task automatic run_frame(input logic [7:0] rows, input logic flag, input int sm_lat,
                           input int cmp_lat, input bit sm_never);
    bit pend, cmp_act;
    int chk, cmp_left;
    o_start = 0; o_reuse = 0; o_done = 0; o_idle_low = 0;
    o_sd_cyc = -1; o_cd_cyc = -1; o_fd_cyc = -1; o_reuse_cyc = -1; o_skip_seen = -1;
    chk = 0; cmp_act = 0; cmp_left = 0;
    bus.frame_valid = 1'b1; bus.row_count = rows; bus.similarity_flag = flag;
    for (int c = 0; c < 300 && o_done == 0; c++) begin
      pend = bus.frame_valid && bus.frame_ready;
      @(negedge clk);
      if (pend) bus.frame_valid = 1'b0;
      bus.compute_done = 1'b0;
      if (!bus.sm_idle) begin
        o_idle_low++;
        chk++;
        if (!sm_never && chk >= sm_lat) begin
          if (!bus.SM_done) o_sd_cyc = c;
          bus.SM_done = 1'b1;
        end
      end else begin
        bus.SM_done = 1'b0;
        chk = 0;
      end
      if (bus.compute_start) begin
        o_start++; cmp_act = 1'b1; cmp_left = cmp_lat;
      end
      if (cmp_act) begin
        if (cmp_left == 0) begin
          bus.compute_done = 1'b1; cmp_act = 1'b0; o_cd_cyc = c;
        end else cmp_left--;
      end
      if (bus.reuse_prev) begin
        o_reuse++; o_reuse_cyc = c; o_skip_seen = int'(bus.skip_cnt);
      end
      if (bus.frame_done) begin
        o_done++; o_fd_cyc = c;
      end
    end
    bus.frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.frame_ready !== 1'b1) begin errors++; $display("FAIL reset_frame_ready got=%b exp=1", bus.frame_ready); end
    checks++; if (bus.sm_idle !== 1'b1) begin errors++; $display("FAIL reset_sm_idle got=%b exp=1", bus.sm_idle); end
    checks++; if (bus.sm_count !== 8'd0) begin errors++; $display("FAIL reset_sm_count got=%0d exp=0", bus.sm_count); end
    checks++; if ({bus.compute_start, bus.reuse_prev, bus.frame_done} !== 3'b000) begin errors++;
      $display("FAIL reset_pulses got=%b exp=000", {bus.compute_start, bus.reuse_prev, bus.frame_done}); end
    checks++; if ({bus.skip_cnt, bus.stat_computed, bus.stat_skipped} !== 35'd0) begin errors++;
      $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", bus.skip_cnt, bus.stat_computed, bus.stat_skipped); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout_err); end
  endtask

  task automatic test_first_frame();
    bit exp_reuse;
    run_frame(8'd8, 1'b0, 3, 2, 1'b0);
    exp_reuse = model_frame(1'b0);
    checks++; if (o_start !== 1 || o_reuse !== 0 || exp_reuse) begin errors++;
      $display("FAIL first_frame_compute starts=%0d reuses=%0d exp=1/0", o_start, o_reuse); end
    checks++; if (o_done !== 1) begin errors++; $display("FAIL first_frame_done got=%0d exp=1", o_done); end
    checks++; if (int'(bus.stat_computed) !== m_comp || int'(bus.skip_cnt) !== m_skip) begin errors++;
      $display("FAIL first_frame_stats got=%0d/%0d exp=%0d/%0d", bus.stat_computed, bus.skip_cnt, m_comp, m_skip); end
    checks++; if (bus.sm_count !== 8'd8) begin errors++; $display("FAIL first_frame_sm_count got=%0d exp=8", bus.sm_count); end
  endtask

  task automatic test_skip_bound();
    bit exp_reuse;
    for (int f = 0; f < 5; f++) begin
      run_frame(8'($urandom_range(1, 255)), 1'b0, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 1'b0);
      exp_reuse = model_frame(1'b0);
      checks++; if (o_reuse !== int'(exp_reuse) || o_start !== int'(!exp_reuse)) begin errors++;
        $display("FAIL skip_bound_decision frame=%0d reuses=%0d starts=%0d exp_reuse=%0d", f, o_reuse, o_start, exp_reuse); end
      checks++; if (int'(bus.skip_cnt) !== m_skip) begin errors++;
        $display("FAIL skip_bound_skip_cnt frame=%0d got=%0d exp=%0d", f, bus.skip_cnt, m_skip); end
      if (exp_reuse) begin
        checks++; if (o_reuse_cyc - o_sd_cyc !== 2 || o_fd_cyc - o_sd_cyc !== 3 || o_skip_seen !== m_skip) begin errors++;
          $display("FAIL skip_bound_latency reuse_dt=%0d done_dt=%0d skip=%0d exp=2/3/%0d",
                   o_reuse_cyc - o_sd_cyc, o_fd_cyc - o_sd_cyc, o_skip_seen, m_skip); end
      end
    end
    checks++; if (int'(bus.stat_skipped) !== m_skipped || m_skipped !== 4) begin errors++;
      $display("FAIL skip_bound_stat_skipped got=%0d exp=%0d", bus.stat_skipped, m_skipped); end
  endtask

  task automatic test_flag_set(input int cmp_lat);
    bit exp_reuse;
    run_frame(8'd20, 1'b1, 2, cmp_lat, 1'b0);
    exp_reuse = model_frame(1'b1);
    checks++; if (o_start !== 1 || o_reuse !== 0 || exp_reuse) begin errors++;
      $display("FAIL flag_set_compute lat=%0d starts=%0d reuses=%0d exp=1/0", cmp_lat, o_start, o_reuse); end
    checks++; if (o_fd_cyc !== o_cd_cyc + 1 || o_done !== 1) begin errors++;
      $display("FAIL flag_set_done_timing lat=%0d done_cyc=%0d cdone_cyc=%0d", cmp_lat, o_fd_cyc, o_cd_cyc); end
    checks++; if (int'(bus.stat_computed) !== m_comp || bus.skip_cnt !== 3'd0) begin errors++;
      $display("FAIL flag_set_stats got=%0d/%0d exp=%0d/0", bus.stat_computed, bus.skip_cnt, m_comp); end
  endtask

  task automatic test_zero_rows();
    bit exp_reuse;
    run_frame(8'd0, 1'b0, 1, 1, 1'b0);
    exp_reuse = model_frame(1'b1);
    checks++; if (o_idle_low !== 0) begin errors++; $display("FAIL zero_rows_sm_idle low_cycles=%0d exp=0", o_idle_low); end
    checks++; if (o_start !== 1 || o_reuse !== 0 || o_done !== 1 || exp_reuse) begin errors++;
      $display("FAIL zero_rows_compute starts=%0d reuses=%0d dones=%0d exp=1/0/1", o_start, o_reuse, o_done); end
    checks++; if (bus.sm_count !== 8'd0) begin errors++; $display("FAIL zero_rows_sm_count got=%0d exp=0", bus.sm_count); end
  endtask

  task automatic test_sm_done_tie();
    bit exp_reuse;
    run_frame(8'd3, 1'b0, TIMEOUT + 1, 0, 1'b0);
    exp_reuse = model_frame(1'b0);
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tie_timeout_err got=%b exp=0", bus.timeout_err); end
    checks++; if (o_reuse !== int'(exp_reuse) || o_idle_low !== TIMEOUT + 1) begin errors++;
      $display("FAIL tie_decision reuses=%0d low=%0d exp=%0d/%0d", o_reuse, o_idle_low, exp_reuse, TIMEOUT + 1); end
  endtask

  task automatic test_timeout();
    bit exp_reuse;
    run_frame(8'd4, 1'b0, 1, 1, 1'b1);
    exp_reuse = model_frame(1'b1);
    checks++; if (o_idle_low !== TIMEOUT + 1) begin errors++;
      $display("FAIL timeout_check_cycles got=%0d exp=%0d", o_idle_low, TIMEOUT + 1); end
    checks++; if (bus.timeout_err !== 1'b1 || bus.sm_idle !== 1'b1) begin errors++;
      $display("FAIL timeout_flags err=%b idle=%b exp=1/1", bus.timeout_err, bus.sm_idle); end
    checks++; if (o_start !== 1 || o_reuse !== 0 || o_done !== 1 || exp_reuse) begin errors++;
      $display("FAIL timeout_compute starts=%0d reuses=%0d dones=%0d exp=1/0/1", o_start, o_reuse, o_done); end
  endtask

  task automatic test_random();
    logic [7:0] rows;
    bit flag, exp_reuse;
    for (int f = 0; f < 24; f++) begin
      rows = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      flag = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      bus.compute_done = ($urandom_range(0, 1) == 1);
      run_frame(rows, flag, int'($urandom_range(1, 12)), int'($urandom_range(0, 4)), 1'b0);
      exp_reuse = model_frame(flag || (rows == 8'd0));
      checks++; if (o_reuse !== int'(exp_reuse) || o_start !== int'(!exp_reuse) || o_done !== 1) begin errors++;
        $display("FAIL random_decision frame=%0d reuses=%0d starts=%0d dones=%0d exp_reuse=%0d", f, o_reuse, o_start, o_done, exp_reuse); end
      checks++; if (int'(bus.skip_cnt) !== m_skip || int'(bus.stat_computed) !== m_comp ||
                    int'(bus.stat_skipped) !== m_skipped || bus.sm_count !== rows) begin errors++;
        $display("FAIL random_state frame=%0d skip=%0d comp=%0d skipped=%0d cnt=%0d exp=%0d/%0d/%0d/%0d",
                 f, bus.skip_cnt, bus.stat_computed, bus.stat_skipped, bus.sm_count, m_skip, m_comp, m_skipped, rows); end
    end
  endtask

  task automatic test_reset_mid_compute();
    bit seen, pend, exp_reuse;
    int fd;
    seen = 1'b0;
    bus.frame_valid = 1'b1; bus.row_count = 8'd5; bus.similarity_flag = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      pend = bus.frame_valid && bus.frame_ready;
      @(negedge clk);
      if (pend) bus.frame_valid = 1'b0;
      bus.SM_done = !bus.sm_idle;
      if (bus.compute_start) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_mid_compute_start got=0 exp=1"); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.frame_ready !== 1'b1 || bus.sm_idle !== 1'b1 || bus.sm_count !== 8'd0) begin errors++;
      $display("FAIL rst_mid_async_ctrl ready=%b idle=%b cnt=%0d exp=1/1/0", bus.frame_ready, bus.sm_idle, bus.sm_count); end
    checks++; if (bus.stat_computed !== 16'd0 || bus.stat_skipped !== 16'd0 || bus.skip_cnt !== 3'd0 || bus.timeout_err !== 1'b0) begin errors++;
      $display("FAIL rst_mid_async_stats comp=%0d skip=%0d cnt=%0d to=%b exp=0", bus.stat_computed, bus.stat_skipped, bus.skip_cnt, bus.timeout_err); end
    bus.SM_done = 1'b0; bus.frame_valid = 1'b0; bus.compute_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    fd = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.frame_done) fd++;
    end
    checks++; if (fd !== 0) begin errors++; $display("FAIL rst_mid_no_frame_done got=%0d exp=0", fd); end
    m_first = 1'b1; m_skip = 0; m_comp = 0; m_skipped = 0;
    run_frame(8'd8, 1'b0, 2, 1, 1'b0);
    exp_reuse = model_frame(1'b0);
    checks++; if (o_start !== 1 || o_reuse !== 0 || exp_reuse || bus.stat_computed !== 16'd1) begin errors++;
      $display("FAIL rst_mid_first_frame starts=%0d reuses=%0d comp=%0d exp=1/0/1", o_start, o_reuse, bus.stat_computed); end
  endtask

  initial begin
    bus.frame_valid = 1'b0; bus.row_count = '0; bus.similarity_flag = 1'b0;
    bus.SM_done = 1'b0; bus.compute_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_frame();
    test_skip_bound();
    test_flag_set(3);
    test_flag_set(0);
    test_zero_rows();
    test_sm_done_tie();
    test_timeout();
    test_random();
    test_reset_mid_compute();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
